csr_file: RTL

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_counter.sv | 25 ++
 rtl/csr_file.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Machine-mode CSR file constants: addresses, op encoding, FSM states, bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2
    } csr_state_e;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MEIE_BIT = 11;
    localparam int MEIP_BIT = 11;

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-bit counter with a load port that overrides the increment.
// Latency: load or increment visible one cycle after the edge.
// Backpressure: none; wraps silently at 2^XLEN-1.
module csr_counter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_val,
    input  logic            inc_en,
    output logic [XLEN-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_val;
        end else if (inc_en) begin
            count <= count + XLEN'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap/mret sequencing and fetch redirect.
// Latency: reads combinational, writes at next edge, redirect one cycle after the request edge.
// Backpressure: trap/mret/CSR ops are ignored while busy; no stalls are generated.
module csr_file
    import csr_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    input  logic            instr_retired,
    input  logic            ext_irq,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            irq_pending
);

    csr_state_e      state;
    logic            st_mie;
    logic            st_mpie;
    logic            st_meie;
    logic            st_meip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic            idle;
    logic            addr_hit;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_val;
    logic            wr_en;
    logic [XLEN-1:0] trap_base;

    assign idle = (state == ST_IDLE);
    assign busy = !idle;

    always_comb begin
        rd_val   = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                rd_val[MIE_BIT]  = st_mie;
                rd_val[MPIE_BIT] = st_mpie;
            end
            CSR_MIE:      rd_val[MEIE_BIT] = st_meie;
            CSR_MTVEC:    rd_val = mtvec;
            CSR_MEPC:     rd_val = mepc;
            CSR_MCAUSE:   rd_val = mcause;
            CSR_MIP:      rd_val[MEIP_BIT] = st_meip;
            CSR_MCYCLE: begin
                addr_hit = HAS_COUNTERS;
                rd_val   = mcycle;
            end
            CSR_MINSTRET: begin
                addr_hit = HAS_COUNTERS;
                rd_val   = minstret;
            end
            default:      addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = rd_val;
    assign csr_illegal = idle && (csr_op != OP_NONE) && !addr_hit;

    always_comb begin
        case (csr_op)
            OP_RW:   wr_val = csr_wdata;
            OP_RS:   wr_val = rd_val | csr_wdata;
            OP_RC:   wr_val = rd_val & ~csr_wdata;
            default: wr_val = rd_val;
        endcase
    end

    // A zero mask on RS/RC is a pure read and must not disturb side-effecting registers.
    assign wr_en = idle && !trap_req && (csr_op != OP_NONE) && addr_hit &&
                   !(((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            st_meie <= 1'b0;
            st_meip <= 1'b0;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            st_meip <= ext_irq;
            case (state)
                ST_IDLE: begin
                    if (trap_req) begin
                        mepc    <= trap_pc & ~XLEN'(3);
                        mcause  <= trap_cause;
                        st_mpie <= st_mie;
                        st_mie  <= 1'b0;
                        state   <= ST_TRAP;
                    end else begin
                        if (mret_req) begin
                            st_mie  <= st_mpie;
                            st_mpie <= 1'b1;
                            state   <= ST_MRET;
                        end
                        if (wr_en) begin
                            case (csr_addr)
                                CSR_MSTATUS: begin
                                    if (!mret_req) begin
                                        st_mie  <= wr_val[MIE_BIT];
                                        st_mpie <= wr_val[MPIE_BIT];
                                    end
                                end
                                CSR_MIE:    st_meie <= wr_val[MEIE_BIT];
                                CSR_MTVEC:  mtvec   <= wr_val & ~XLEN'(2);
                                CSR_MEPC:   mepc    <= wr_val & ~XLEN'(3);
                                CSR_MCAUSE: mcause  <= wr_val;
                                default:    ;
                            endcase
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter #(.XLEN(XLEN)) u_mcycle (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_en  (wr_en && (csr_addr == CSR_MCYCLE)),
                .load_val (wr_val),
                .inc_en   (1'b1),
                .count    (mcycle)
            );
            csr_counter #(.XLEN(XLEN)) u_minstret (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_en  (wr_en && (csr_addr == CSR_MINSTRET)),
                .load_val (wr_val),
                .inc_en   (instr_retired),
                .count    (minstret)
            );
        end else begin : g_no_counters
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

    // Vectored mode only applies to interrupts; the cause index is taken from the saved mcause.
    always_comb begin
        trap_base = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[0] && mcause[XLEN-1]) begin
            trap_base = trap_base + {mcause[XLEN-3:0], 2'b00};
        end
    end

    always_comb begin
        redirect_valid = !idle;
        case (state)
            ST_TRAP: redirect_pc = trap_base;
            ST_MRET: redirect_pc = mepc;
            default: redirect_pc = '0;
        endcase
    end

    assign irq_pending = st_mie & st_meie & st_meip;

endmodule
